// File: rtl/unified_mem_sys.sv
// Shared single-port word RAM behind separate instruction/data req-gnt-rvalid ports.
// Optional grant/stall performance counters are enabled by defining MEM_PERF_CNT_EN.
module unified_mem_sys #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH_WORDS);
    localparam logic [SW-1:0]     STARVE_V  = SW'(STARVE_MAX);
    localparam logic [3:0]        WAIT_LAST = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_r;
    logic [3:0]        wait_cnt_r;
    logic [SW-1:0]     starve_r;
    logic              sel_d_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic              i_rvalid_r, d_rvalid_r, i_err_r, d_err_r;
    logic [31:0]       i_rdata_r, d_rdata_r;
    logic [31:0]       mem_r [DEPTH_WORDS];

    logic              i_win_s;
    logic              idle_s;
    logic              err_s;
    logic [IDX_W-1:0]  idx_s;

    // Misaligned or beyond-the-array word index makes an access illegal
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH_A);
    endfunction

    // Data port has priority unless it is idle or the fetch port has starved long enough
    always_comb begin
        i_win_s = 1'b0;
        if (!d_req) begin
            i_win_s = 1'b1;
        end else if (i_req && (starve_r == STARVE_V)) begin
            i_win_s = 1'b1;
        end else begin
            i_win_s = 1'b0;
        end
    end

    assign idle_s = (state_r == IDLE) && !rst;
    assign i_gnt  = idle_s && i_req && i_win_s;
    assign d_gnt  = idle_s && d_req && !i_win_s;
    assign err_s  = addr_err(addr_r);
    assign idx_s  = addr_r[IDX_W+1:2];

    // Transaction sequencer: arbitration, request capture, wait states and response strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= 4'd0;
            starve_r   <= '0;
            sel_d_r    <= 1'b0;
            addr_r     <= '0;
            we_r       <= 1'b0;
            be_r       <= 4'd0;
            wdata_r    <= 32'd0;
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_err_r    <= 1'b0;
            d_err_r    <= 1'b0;
            i_rdata_r  <= 32'd0;
            d_rdata_r  <= 32'd0;
        end else begin
            i_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            i_err_r    <= 1'b0;
            d_err_r    <= 1'b0;
            i_rdata_r  <= 32'd0;
            d_rdata_r  <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (i_gnt || !i_req) begin
                        starve_r <= '0;
                    end else if (d_gnt) begin
                        starve_r <= starve_r + SW'(1);
                    end else begin
                        starve_r <= starve_r;
                    end
                    if (i_gnt || d_gnt) begin
                        sel_d_r    <= d_gnt;
                        addr_r     <= d_gnt ? d_addr : i_addr;
                        we_r       <= d_gnt && d_we;
                        be_r       <= d_be;
                        wdata_r    <= d_wdata;
                        wait_cnt_r <= 4'd0;
                        state_r    <= (WAIT_CYCLES > 0) ? WAIT : RESP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        wait_cnt_r <= 4'd0;
                        state_r    <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 4'd1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    if (sel_d_r) begin
                        d_rvalid_r <= 1'b1;
                        d_err_r    <= err_s;
                        d_rdata_r  <= (we_r || err_s) ? 32'd0 : mem_r[idx_s];
                    end else begin
                        i_rvalid_r <= 1'b1;
                        i_err_r    <= err_s;
                        i_rdata_r  <= err_s ? 32'd0 : mem_r[idx_s];
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane RAM write, committed only at the RESP edge of a legal data write
    always_ff @(posedge clk) begin
        if (!rst && (state_r == RESP) && sel_d_r && we_r && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_r[k]) begin
                    mem_r[idx_s][8*k +: 8] <= wdata_r[8*k +: 8];
                end
            end
        end
    end

    assign i_rvalid = i_rvalid_r;
    assign i_rdata  = i_rdata_r;
    assign i_err    = i_err_r;
    assign d_rvalid = d_rvalid_r;
    assign d_rdata  = d_rdata_r;
    assign d_err    = d_err_r;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_i_r, perf_d_r, perf_stall_r;

    // Grant and stall event counters, wrapping naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_r     <= 32'd0;
            perf_d_r     <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (i_gnt) begin
                perf_i_r <= perf_i_r + 32'd1;
            end
            if (d_gnt) begin
                perf_d_r <= perf_d_r + 32'd1;
            end
            if ((i_req && !i_gnt) || (d_req && !d_gnt)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_i_cnt     = perf_i_r;
    assign perf_d_cnt     = perf_d_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: doc/unified_mem_sys.md
Name: unified_mem_sys

Overview:
- Parametrised memory subsystem for the MIPS core: one inferred single-port word RAM shared by an instruction-fetch port and a data port.
- Replaces the separate fixed-depth instruction/data block RAMs clocked on inverted clock with a posedge-only, req/gnt/rvalid handshake. The pipelined core can therefore stall on memory.
- Adds byte-enable writes, configurable wait states, bounded-starvation arbitration and range/alignment error reporting.

Parameters:
ADDR_W, 32, byte-address width of both ports
DEPTH_WORDS, 1024, RAM depth in 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
WAIT_CYCLES, 0, extra stall cycles inserted between accept and response (0..15)
STARVE_MAX, 4, consecutive data grants allowed while i_req pending before instruction port is forced

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  instruction fetch request
i_addr  in  ADDR_W  fetch byte address
i_gnt  out  1  fetch accepted this cycle (combinational)
i_rvalid  out  1  one-cycle fetch response strobe
i_rdata  out  32  fetched word
i_err  out  1  fetch error, valid with i_rvalid
d_req  in  1  data request
d_we  in  1  1=write, 0=read
d_be  in  4  byte enables, bit k = byte lane k (bits 8k+7:8k)
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  write data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  one-cycle data response strobe (reads and write acks)
d_rdata  out  32  read data, 0 on write ack or error
d_err  out  1  data error, valid with d_rvalid

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- FSM states: IDLE, WAIT, RESP. Reset -> IDLE.
- Reset values: all outputs 0, wait counter 0, starvation counter 0. RAM contents are not cleared.
- Grants:
  - Granting happens only in IDLE. At most one of i_gnt/d_gnt is high.
  - Default priority: data. Instruction wins when d_req=0, or when the starvation counter = STARVE_MAX and i_req=1.
- Starvation counter:
  - Increments on each d_gnt while i_req=1.
  - Clears on i_gnt, or on any IDLE cycle with i_req=0.
- Accept: on the edge where req && gnt, the port id, address, we, be and wdata are latched. Inputs may change afterwards.
- Next state after accept: WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counts WAIT_CYCLES cycles, then moves to RESP.
- RESP:
  - RAM read/write occurs at the RESP edge.
  - The selected rvalid is high for exactly the cycle after RESP, with rdata/err valid, and the FSM returns to IDLE in that same cycle.
  - Latency: accept at edge N -> rvalid high in cycle N+2+WAIT_CYCLES. Max throughput is one transaction per 2+WAIT_CYCLES cycles.
- Writes: only lanes with d_be[k]=1 are updated. d_be=0 is a legal no-op write, acked normally.
- Errors:
  - Word index addr[ADDR_W-1:2] >= DEPTH_WORDS -> err=1, write suppressed, rdata=0.
  - addr[1:0] != 0 -> err=1, write suppressed, rdata=0. Sub-word alignment is the core's job: lane-select via d_be.
  - Instruction-port errors return i_rdata=32'h0 (nop).
- Simultaneous i_req and d_req in IDLE: resolved by the priority rule. The loser simply sees gnt=0 and must hold req.
- req dropped without gnt: no effect.
- Reset mid-operation (WAIT or RESP): FSM -> IDLE, no rvalid issued, pending write not committed unless the RESP edge already occurred.
- Read-after-write to the same address in the next transaction returns the new data.

Optional Feature:
- Macro: MEM_PERF_CNT_EN.
- When defined, adds outputs perf_i_cnt (32), perf_d_cnt (32) and perf_stall_cnt (32):
  - perf_i_cnt / perf_d_cnt count grants per port.
  - perf_stall_cnt counts cycles where any req=1 and its gnt=0.
  - All cleared by rst; each wraps 32'hFFFFFFFF -> 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=0: d write addr 0x10, be=4'hF, wdata 0xDEADBEEF; then d read 0x10 -> d_rvalid 2 cycles after each accept, d_rdata=0xDEADBEEF, d_err=0.
- Byte enables: after the above, write be=4'b0010, wdata 0x0000AA00 to 0x10; read -> 0xDEADAAEF.
- WAIT_CYCLES=3: i_req addr 0x0 holding word 0x20080005 -> i_rvalid exactly 5 cycles after accept, i_rdata=0x20080005.
- Arbitration, STARVE_MAX=4: i_req and d_req held high continuously -> grant order D,D,D,D,I,D,D,D,D,I...; no i_gnt/d_gnt overlap.
- Errors, DEPTH_WORDS=1024: d read 0x1000 -> d_err=1, d_rdata=0; d write 0x12 -> d_err=1, RAM word 0x10 unchanged; fetch 0x2000 -> i_err=1, i_rdata=0.
- Reset mid-op, WAIT_CYCLES=3: d write 0x20 wdata 0x12345678, assert rst one cycle during WAIT -> no d_rvalid, state IDLE; subsequent read of 0x20 returns prior contents.
